// File: rtl/frontend_pkg.sv
// Purpose: shared front-end geometry and the fetch-bundle layout used by fetch, IF/ID and decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frontend_pkg;

  localparam int SLOTS    = 4;
  localparam int XLEN     = 16;
  localparam int BUNDLE_W = SLOTS * XLEN;

  // Slot 0 (oldest) sits in the most-significant field of every vector;
  // for pred, slot 0 is the MSB.
  typedef struct packed {
    logic [BUNDLE_W-1:0] pc;
    logic [BUNDLE_W-1:0] inst;
    logic [BUNDLE_W-1:0] recv_pc;
    logic [SLOTS-1:0]    pred;
  } fetch_bundle_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Purpose: fetch->decode bundle bus through the IF/ID register, plus the stall control.
// Latency: n/a (wiring only).
// Backpressure: stall from decode freezes the register; fetch must hold its bundle meanwhile.
//
// Signals:
//   pc/inst/recv_pc_if_id_in  SLOTS*XLEN  bundle from fetch
//   pred_result_if_id_in      SLOTS       per-slot predicted-taken bits
//   stall                     1           1 = register keeps its contents
//   *_if_id_out                           registered copies towards decode
// Modports: slave = the pipeline register, master = the fetch/decode side driving it.
interface if_id_pipe_reg_if #(
  parameter int SLOTS = frontend_pkg::SLOTS,
  parameter int XLEN  = frontend_pkg::XLEN
);

  logic [SLOTS*XLEN-1:0] pc_if_id_in;
  logic [SLOTS*XLEN-1:0] inst_if_id_in;
  logic [SLOTS*XLEN-1:0] recv_pc_if_id_in;
  logic [SLOTS-1:0]      pred_result_if_id_in;
  logic                  stall;

  logic [SLOTS*XLEN-1:0] pc_if_id_out;
  logic [SLOTS*XLEN-1:0] inst_if_id_out;
  logic [SLOTS*XLEN-1:0] recv_pc_if_id_out;
  logic [SLOTS-1:0]      pred_result_if_id_out;

  modport slave (
    input  pc_if_id_in, inst_if_id_in, recv_pc_if_id_in, pred_result_if_id_in, stall,
    output pc_if_id_out, inst_if_id_out, recv_pc_if_id_out, pred_result_if_id_out
  );

  modport master (
    output pc_if_id_in, inst_if_id_in, recv_pc_if_id_in, pred_result_if_id_in, stall,
    input  pc_if_id_out, inst_if_id_out, recv_pc_if_id_out, pred_result_if_id_out
  );

endinterface

// File: rtl/pipe_reg_en.sv
// Purpose: W-bit register with load enable and asynchronous active-low clear to zero.
// Latency: 1 cycle from d to q when en = 1.
// Backpressure: en = 0 holds q indefinitely.
//
// Ports: clk, rst_n (async clear), en (load enable), d (next value), q (registered value).
module pipe_reg_en #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Purpose: IF/ID pipeline register capturing one 4-wide fetch bundle (pc, inst, recv_pc, pred).
// Latency: 1 cycle; outputs are pure flops, no input-to-output combinational path.
// Backpressure: stall = 1 freezes all four fields together; reset clears them and wins over stall.
//
// Ports: clk, rst_n (async active-low), bus (if_id_pipe_reg_if.slave: fetch inputs, stall,
//        registered outputs to decode).
module if_id_pipe_reg #(
  parameter int SLOTS = frontend_pkg::SLOTS,
  parameter int XLEN  = frontend_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  if_id_pipe_reg_if.slave   bus
);

  localparam int BW = SLOTS * XLEN;

  // One shared enable so a stall can never freeze only part of the bundle.
  logic load_en;
  assign load_en = ~bus.stall;

  pipe_reg_en #(.W(BW)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (bus.pc_if_id_in),
    .q     (bus.pc_if_id_out)
  );

  pipe_reg_en #(.W(BW)) u_inst_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (bus.inst_if_id_in),
    .q     (bus.inst_if_id_out)
  );

  pipe_reg_en #(.W(BW)) u_recv_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (bus.recv_pc_if_id_in),
    .q     (bus.recv_pc_if_id_out)
  );

  pipe_reg_en #(.W(SLOTS)) u_pred_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (bus.pred_result_if_id_in),
    .q     (bus.pred_result_if_id_out)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Purpose: self-checking bench for if_id_pipe_reg (reset, pass-through, stall, streaming, async reset, slot order).
// Latency: expects outputs 1 cycle after an unstalled edge.
// Backpressure: drives stall from a vector table and from a random pattern.
module tb_if_id_pipe_reg;
  import frontend_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  if_id_pipe_reg_if bus ();

  if_id_pipe_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    fetch_bundle_t in;
    logic          stall;
    fetch_bundle_t exp;
  } vec_t;

  vec_t          vec[8];
  fetch_bundle_t sb_q[$];
  fetch_bundle_t mdl;
  fetch_bundle_t exp_b;
  fetch_bundle_t bA, bB, bP, bS, bD;

  function automatic fetch_bundle_t mk(logic [63:0] pc, logic [63:0] inst,
                                       logic [63:0] recv, logic [3:0] pred);
    fetch_bundle_t b;
    b.pc      = pc;
    b.inst    = inst;
    b.recv_pc = recv;
    b.pred    = pred;
    return b;
  endfunction

  function automatic fetch_bundle_t rand_b();
    return mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
  endfunction

  function automatic fetch_bundle_t cur_out();
    return mk(bus.pc_if_id_out, bus.inst_if_id_out, bus.recv_pc_if_id_out, bus.pred_result_if_id_out);
  endfunction

  task automatic drive(input fetch_bundle_t b, input logic s);
    bus.pc_if_id_in          = b.pc;
    bus.inst_if_id_in        = b.inst;
    bus.recv_pc_if_id_in     = b.recv_pc;
    bus.pred_result_if_id_in = b.pred;
    bus.stall                = s;
  endtask

  task automatic check_b(input string name, input fetch_bundle_t act, input fetch_bundle_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h inst=%h recv=%h pred=%b, expected pc=%h inst=%h recv=%h pred=%b",
               name, act.pc, act.inst, act.recv_pc, act.pred,
               exp.pc, exp.inst, exp.recv_pc, exp.pred);
    end
  endtask

  task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Absolute time bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    bA = mk(64'hA0A0_A1A1_A2A2_A3A3, 64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEF0, 4'b1010);
    bB = mk(64'hB0B0_B1B1_B2B2_B3B3, 64'h0F0F_F0F0_5555_AAAA, 64'hFEDC_BA98_7654_3210, 4'b0101);
    bP = mk(64'h0000_0001_0002_0003, 64'h1111_2222_3333_4444, 64'h0004_0004_0004_0004, 4'b0100);
    bS = mk(64'h0010_0012_0014_0016, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0020_0022_0024_0026, 4'b1000);

    vec[0] = '{in: bP, stall: 1'b0, exp: bP};   // pass-through
    vec[1] = '{in: bA, stall: 1'b0, exp: bA};   // load A
    vec[2] = '{in: bB, stall: 1'b1, exp: bA};   // stall 1
    vec[3] = '{in: bB, stall: 1'b1, exp: bA};   // stall 2
    vec[4] = '{in: bB, stall: 1'b1, exp: bA};   // stall 3
    vec[5] = '{in: bB, stall: 1'b0, exp: bB};   // stall dropped, B loads
    vec[6] = '{in: bS, stall: 1'b0, exp: bS};   // slot ordering bundle
    vec[7] = '{in: bA, stall: 1'b1, exp: bS};   // stalled edge keeps S

    // Reset with toggling inputs, spanning the clock edge at t=5.
    rst_n = 1'b0;
    drive(bA, 1'b0);
    #2;
    check_b("reset_t2", cur_out(), '0);
    drive(bB, 1'b1);
    #4;
    check_b("reset_after_edge", cur_out(), '0);
    #1 rst_n = 1'b1;
    #1;
    check_b("release_before_edge", cur_out(), '0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vec[i].in, vec[i].stall);
      @(posedge clk);
      #1;
      check_b($sformatf("vec%0d", i), cur_out(), vec[i].exp);
    end
    mdl = vec[7].exp;
    check_v("slot0_inst_msb", {48'h0, bus.inst_if_id_out[63:48]}, 64'hAAAA);
    check_v("slot3_inst_lsb", {48'h0, bus.inst_if_id_out[15:0]}, 64'hDDDD);
    check_v("slot0_pred_bit3", {63'h0, bus.pred_result_if_id_out[3]}, 64'h1);

    // Streaming: 8 unstalled bundles, then 8 with random stall; scoreboard model.
    for (int i = 0; i < 16; i++) begin
      fetch_bundle_t b;
      logic          s;
      b = rand_b();
      s = (i < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      drive(b, s);
      if (!s) mdl = b;
      sb_q.push_back(mdl);
      @(posedge clk);
      #1;
      exp_b = sb_q.pop_front();
      check_b($sformatf("stream%0d", i), cur_out(), exp_b);
    end
    check_v("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    // Async reset pulse between edges while a nonzero bundle is held under stall.
    bD = rand_b();
    bD.pred = 4'b1111;
    @(negedge clk);
    drive(bD, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_b("async_reset_mid", cur_out(), '0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_b("after_release_stalled", cur_out(), '0);
    @(negedge clk);
    drive(bD, 1'b0);
    @(posedge clk);
    #1;
    check_b("reload_after_reset", cur_out(), bD);

    // Reset while stall is high: reset must win.
    @(negedge clk);
    drive(bA, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_b("reset_wins_over_stall", cur_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(bA, 1'b0);
    @(posedge clk);
    #1;
    check_b("reload_A", cur_out(), bA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Pipeline register between the fetch stage and the decode stage (ID_top) of the 4-wide front end. Each cycle it captures one fetch bundle: four 16-bit instruction slots, their PCs, their recovery PCs and their per-slot branch-prediction bits. It presents the captured bundle to decode for the following cycle. A stall input freezes the bundle so decode can back-pressure fetch without losing instructions.

## Interface
Parameters:
- `SLOTS`, default 4: instructions per fetch bundle.
- `XLEN`, default 16: width of one instruction, PC or recovery PC.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: rising-edge clock.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Inputs from fetch:
  - `pc_if_id_in`, in, SLOTS*XLEN (64): PC of each slot.
  - `inst_if_id_in`, in, SLOTS*XLEN (64): instruction word of each slot.
  - `recv_pc_if_id_in`, in, SLOTS*XLEN (64): recovery PC of each slot, i.e. the alternate path used on a mispredict.
  - `pred_result_if_id_in`, in, SLOTS (4): prediction per slot; 1 = predicted taken.
- Control:
  - `stall`, in, 1: 1 = hold the current contents.
- Outputs to decode:
  - `pc_if_id_out`, out, 64: registered PCs.
  - `inst_if_id_out`, out, 64: registered instructions.
  - `recv_pc_if_id_out`, out, 64: registered recovery PCs.
  - `pred_result_if_id_out`, out, 4: registered prediction bits.

## Operation
- Slot packing is in program order, most-significant first:
  - slot 0 (oldest) occupies bits [63:48], slot 3 occupies bits [15:0];
  - for `pred_result`, slot 0 is bit 3 and slot 3 is bit 0.
- The register never reorders, decodes or modifies fields. Each output is a bit-exact copy of its input.
- When `stall` = 0 at a rising edge, all four output fields load their inputs.
- When `stall` = 1 at a rising edge, all four fields keep their previous values. A stall is never partial.
- Reset is asynchronous and active-low. While `rst_n` = 0, all outputs are forced to 0 regardless of `clk` and `stall`:
  - `pc`, `inst` and `recv_pc` outputs read 0x0000_0000_0000_0000;
  - `pred_result` reads 4'b0000;
  - all-zero instruction words are the bundle decode sees out of reset.
- Deassertion of `rst_n` takes effect immediately. The first load happens at the first rising edge with `rst_n` = 1 and `stall` = 0.
- There is no flush input. Mispredict squashing is handled in decode and fetch, not here.

## Timing
- Latency is 1 cycle: the input bundle sampled at edge N appears on the outputs after edge N and stays stable until edge N+1.
- No combinational path exists from any input to any output.
- Stall is sampled at the same edge as the data. A stall asserted at edge N holds the value that was loaded at edge N-1.
- A stall held for k cycles holds the outputs for k cycles. The bundle present at the inputs when stall drops is loaded at the next edge.
- Reset asserted mid-operation clears the outputs asynchronously. After release, they stay 0 until the first unstalled edge.
- Simultaneous reset and stall: reset wins.

## Structure
- A shared package `frontend_pkg` holds:
  - `SLOTS` = 4 and `XLEN` = 16;
  - `BUNDLE_W` = SLOTS*XLEN;
  - a packed bundle typedef covering pc, inst, recv_pc and pred.
- The package is shared with fetch and ID_top.
- One sub-module, `pipe_reg_en`: a parameterized-width register with asynchronous active-low clear and a load enable.
- The top instantiates `pipe_reg_en` four times (64, 64, 64 and 4 bits), with enable = ~stall.

## Test plan
- Reset: hold `rst_n` = 0 for 7 ns with the inputs toggling -> all outputs 0; no change on clock edges while in reset.
- Pass-through: after reset, drive `inst` = 0x1111_2222_3333_4444, `pc` = 0x0000_0001_0002_0003, `recv_pc` = 0x0004_0004_0004_0004, `pred` = 4'b0100 with `stall` = 0 -> identical values on the outputs 1 cycle later.
- Stall hold: load bundle A, then assert `stall` for 3 cycles while driving bundle B -> outputs stay A for all 3 cycles; B appears 1 cycle after stall drops.
- Streaming: new bundles every cycle for 8 cycles with `stall` = 0 -> outputs reproduce the input sequence delayed by exactly 1 cycle, with no drops or duplicates.
- Async reset mid-stream: pulse `rst_n` low between clock edges while a nonzero bundle is held -> outputs go to 0 before the next edge, then reload on the first unstalled edge after release.
- Slot ordering: `pred_result_if_id_in` = 4'b1000 with a distinct word per slot -> the slot-0 word stays in [63:48] and the pred bit stays at bit 3 at the outputs.
